// File: rtl/inst_ram_loader_pkg.sv
// Shared definitions for the instruction-RAM boot loader: state encoding,
// default widths matching the CPU inst-RAM, and timer sizing.
package inst_ram_loader_pkg;

    localparam int unsigned LOADER_DATA_W = 32;
    localparam int unsigned LOADER_ADDR_W = 16;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_WRITE,
        ST_GAP,
        ST_SETTLE,
        ST_RUN
    } loader_state_e;

    // Counter width able to hold the larger of the two programmed intervals.
    function automatic int unsigned timer_width(input int unsigned a, input int unsigned b);
        int unsigned m;
        int unsigned w;
        m = (a > b) ? a : b;
        w = $clog2(m + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/inst_ram_loader_cycle_timer.sv
// Loadable down-counter; 'expired' is high while the count sits at zero.
module inst_ram_loader_cycle_timer #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             en,
    output logic             expired
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_val;
        end else if (en && (count_q != '0)) begin
            count_d = count_q - WIDTH'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expired = (count_q == '0);

endmodule

// File: rtl/inst_ram_loader.sv
// Boot-time loader: holds the CPU, streams words into consecutive inst-RAM
// addresses with a configurable gap, waits a settle time, then releases the CPU.
module inst_ram_loader
    import inst_ram_loader_pkg::*;
#(
    parameter int unsigned       DATA_W        = LOADER_DATA_W,
    parameter int unsigned       ADDR_W        = LOADER_ADDR_W,
    parameter logic [ADDR_W-1:0] BASE_ADDR     = '0,
    parameter int unsigned       GAP_CYCLES    = 1,
    parameter int unsigned       SETTLE_CYCLES = 88
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] prog_len,
    input  logic              src_valid,
    input  logic [DATA_W-1:0] src_data,
    output logic              src_ready,
    output logic              inst_ram_write_enable,
    output logic [DATA_W-1:0] inst_ram_write_data,
    output logic [ADDR_W-1:0] inst_ram_write_address,
    output logic              cpu_reset,
    output logic              debug,
    output logic              busy,
    output logic              done
);

    localparam int unsigned TW = timer_width(GAP_CYCLES, SETTLE_CYCLES);
    // Timer is loaded with N-1 on entry so the state lasts exactly N cycles.
    localparam logic [TW-1:0] GAP_LOAD    = TW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
    localparam logic [TW-1:0] SETTLE_LOAD = TW'((SETTLE_CYCLES > 0) ? SETTLE_CYCLES - 1 : 0);

    loader_state_e     state_q, state_d;
    logic [ADDR_W-1:0] remaining_q, remaining_d;
    logic [ADDR_W-1:0] address_q, address_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              we_q, we_d;
    logic              src_ready_q, src_ready_d;
    logic              cpu_reset_q, cpu_reset_d;
    logic              debug_q, debug_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic [ADDR_W-1:0] rem_dec;
    logic              tmr_load;
    logic [TW-1:0]     tmr_val;
    logic              tmr_en;
    logic              tmr_expired;

    inst_ram_loader_cycle_timer #(
        .WIDTH(TW)
    ) u_timer (
        .clk     (clk),
        .reset   (reset),
        .load    (tmr_load),
        .load_val(tmr_val),
        .en      (tmr_en),
        .expired (tmr_expired)
    );

    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        address_d   = address_q;
        data_d      = data_q;
        tmr_load    = 1'b0;
        tmr_val     = '0;
        tmr_en      = 1'b0;
        rem_dec     = remaining_q - ADDR_W'(1);

        unique case (state_q)
            ST_IDLE, ST_RUN: begin
                if (start) begin
                    remaining_d = prog_len;
                    address_d   = BASE_ADDR;
                    if (prog_len == '0) begin
                        state_d  = ST_SETTLE;
                        tmr_load = 1'b1;
                        tmr_val  = SETTLE_LOAD;
                    end else begin
                        state_d = ST_FETCH;
                    end
                end
            end
            ST_FETCH: begin
                if (src_valid && src_ready_q) begin
                    data_d  = src_data;
                    state_d = ST_WRITE;
                end
            end
            ST_WRITE: begin
                address_d   = address_q + ADDR_W'(1);
                remaining_d = rem_dec;
                if (GAP_CYCLES != 0) begin
                    state_d  = ST_GAP;
                    tmr_load = 1'b1;
                    tmr_val  = GAP_LOAD;
                end else if (rem_dec != '0) begin
                    state_d = ST_FETCH;
                end else begin
                    state_d  = ST_SETTLE;
                    tmr_load = 1'b1;
                    tmr_val  = SETTLE_LOAD;
                end
            end
            ST_GAP: begin
                tmr_en = 1'b1;
                if (tmr_expired) begin
                    if (remaining_q != '0) begin
                        state_d = ST_FETCH;
                    end else begin
                        state_d  = ST_SETTLE;
                        tmr_load = 1'b1;
                        tmr_val  = SETTLE_LOAD;
                    end
                end
            end
            ST_SETTLE: begin
                tmr_en = 1'b1;
                if (tmr_expired) begin
                    state_d = ST_RUN;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Outputs are decoded from the next state so they arrive registered.
        src_ready_d = (state_d == ST_FETCH);
        we_d        = (state_d == ST_WRITE);
        cpu_reset_d = (state_d != ST_RUN);
        debug_d     = (state_d != ST_RUN);
        done_d      = (state_d == ST_RUN);
        busy_d      = (state_d != ST_RUN) && (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            remaining_q <= '0;
            address_q   <= BASE_ADDR;
            data_q      <= '0;
            we_q        <= 1'b0;
            src_ready_q <= 1'b0;
            cpu_reset_q <= 1'b1;
            debug_q     <= 1'b1;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
            address_q   <= address_d;
            data_q      <= data_d;
            we_q        <= we_d;
            src_ready_q <= src_ready_d;
            cpu_reset_q <= cpu_reset_d;
            debug_q     <= debug_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign src_ready              = src_ready_q;
    assign inst_ram_write_enable  = we_q;
    assign inst_ram_write_data    = data_q;
    assign inst_ram_write_address = address_q;
    assign cpu_reset              = cpu_reset_q;
    assign debug                  = debug_q;
    assign busy                   = busy_q;
    assign done                   = done_q;

endmodule
